// File: rtl/tbd_accel_ctrl.sv
// Purpose: OBI register front-end and single-job sequencer for the user-domain accelerator.
// Latency: every OBI request is granted the same cycle; its response follows exactly one cycle later.
// Backpressure: OBI is never stalled; a job is held on accel_valid_o until accel_ready_i is seen.
//
// Ports:
//   clk_i, rst_ni         clock; synchronous active-low reset
//   obi_*                 OBI subordinate (req/gnt, addr/we/be/wdata/aid in; rvalid/rdata/rid/err out)
//   accel_valid_o/ready_i job handshake carrying accel_op_a_o/accel_op_b_o
//   accel_result_*        single-cycle result strobe and data from the datapath
//   irq_o                 level interrupt, DONE & IRQ_EN, registered
// Optional feature: define TBD_ACCEL_CTRL_TIMEOUT_EN to abort jobs after TimeoutCycles cycles.
module tbd_accel_ctrl #(
  parameter int unsigned IdWidth       = 1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               obi_req_i,
  output logic               obi_gnt_o,
  input  logic [31:0]        obi_addr_i,
  input  logic               obi_we_i,
  input  logic [3:0]         obi_be_i,
  input  logic [31:0]        obi_wdata_i,
  input  logic [IdWidth-1:0] obi_aid_i,
  output logic               obi_rvalid_o,
  output logic [31:0]        obi_rdata_o,
  output logic [IdWidth-1:0] obi_rid_o,
  output logic               obi_err_o,
  output logic               accel_valid_o,
  input  logic               accel_ready_i,
  output logic [31:0]        accel_op_a_o,
  output logic [31:0]        accel_op_b_o,
  input  logic               accel_result_valid_i,
  input  logic [31:0]        accel_result_i,
  output logic               irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  state_e state_q, state_d;

  logic [31:0]        opa_q, opb_q, result_q, cycles_q;
  logic               irq_en_q, done_q, err_q, timeout_q, irq_q;
  logic               rvalid_q, rsp_err_q;
  logic [31:0]        rdata_q;
  logic [IdWidth-1:0] rid_q;

  logic [7:0]  reg_idx;
  logic        busy;
  logic        wr_req, ctrl_wr, start_wr, clr_wr, start_ok;
  logic        opa_wr, opb_wr, sw_err, capture, timeout_hit;
  logic        rsp_err_d;
  logic [31:0] rdata_d;
  logic        addr_unused;

  assign reg_idx     = obi_addr_i[9:2];
  assign addr_unused = ^{obi_addr_i[31:10], obi_addr_i[1:0]};

  assign wr_req   = obi_req_i & obi_we_i;
  assign ctrl_wr  = wr_req & (reg_idx == 8'd0) & obi_be_i[0];
  assign start_wr = ctrl_wr & obi_wdata_i[0];
  assign clr_wr   = ctrl_wr & obi_wdata_i[2];
  assign start_ok = start_wr & ~busy;
  assign opa_wr   = wr_req & (reg_idx == 8'd2);
  assign opb_wr   = wr_req & (reg_idx == 8'd3);
  // Touching the job (restart or operand change) while it runs is a software error.
  assign sw_err   = busy & (start_wr | opa_wr | opb_wr);
  assign capture  = (state_q == ST_WAIT) & accel_result_valid_i;

`ifdef TBD_ACCEL_CTRL_TIMEOUT_EN
  // A result arriving on the limit cycle still counts as a normal completion.
  assign timeout_hit = busy & (cycles_q >= 32'(TimeoutCycles)) & ~capture;
`else
  logic timeout_unused;
  assign timeout_unused = |32'(TimeoutCycles);
  assign timeout_hit    = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_ISSUE;
      ST_ISSUE: if (timeout_hit) state_d = ST_IDLE;
                else if (accel_ready_i) state_d = ST_WAIT;
      ST_WAIT:  if (capture || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy          = (state_q != ST_IDLE);
    accel_valid_o = (state_q == ST_ISSUE);
  end

  // Register file and job bookkeeping. Later assignments win, so hardware
  // sets of DONE/ERR/TIMEOUT override a CLR arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cycles_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= obi_wdata_i[1];
      if (clr_wr) begin
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (capture || timeout_hit) done_q <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
      if (sw_err) err_q <= 1'b1;
      if (capture) result_q <= accel_result_i;

      if (start_ok) cycles_q <= '0;
      else if (busy && !timeout_hit && cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;

      for (int b = 0; b < 4; b++) begin
        if (opa_wr && !busy && obi_be_i[b]) opa_q[8*b +: 8] <= obi_wdata_i[8*b +: 8];
        if (opb_wr && !busy && obi_be_i[b]) opb_q[8*b +: 8] <= obi_wdata_i[8*b +: 8];
      end

      irq_q <= done_q & irq_en_q;
    end
  end

  // Response decode: values are taken at the grant cycle, before any update.
  always_comb begin
    rsp_err_d = 1'b0;
    rdata_d   = '0;
    if (obi_req_i) begin
      case (reg_idx)
        8'd0: if (!obi_we_i) rdata_d = {30'd0, irq_en_q, 1'b0};
        8'd1: if (obi_we_i) rsp_err_d = 1'b1;
              else rdata_d = {28'd0, timeout_q, err_q, done_q, busy};
        8'd2: if (!obi_we_i) rdata_d = opa_q;
        8'd3: if (!obi_we_i) rdata_d = opb_q;
        8'd4: if (obi_we_i) rsp_err_d = 1'b1;
              else rdata_d = result_q;
        8'd5: if (obi_we_i) rsp_err_d = 1'b1;
              else rdata_d = cycles_q;
        default: rsp_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
    end else begin
      rvalid_q  <= obi_req_i;
      rsp_err_q <= rsp_err_d;
      rdata_q   <= rdata_d;
      if (obi_req_i) rid_q <= obi_aid_i;
    end
  end

  assign obi_gnt_o    = obi_req_i;
  assign obi_rvalid_o = rvalid_q;
  assign obi_err_o    = rsp_err_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_rid_o    = rid_q;
  assign accel_op_a_o = opa_q;
  assign accel_op_b_o = opb_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_tbd_accel_ctrl.sv
// Purpose: self-checking bench for tbd_accel_ctrl against a job-level reference model.
// Latency: model predicts OBI responses one cycle after grant and irq one cycle after DONE.
// Backpressure: datapath ready/result are driven directly or randomly by the bench.
module tb_tbd_accel_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        obi_req_i = 1'b0;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i = '0;
  logic        obi_we_i = 1'b0;
  logic [3:0]  obi_be_i = '0;
  logic [31:0] obi_wdata_i = '0;
  logic [0:0]  obi_aid_i = '0;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic [0:0]  obi_rid_o;
  logic        obi_err_o;
  logic        accel_valid_o;
  logic        accel_ready_i = 1'b0;
  logic [31:0] accel_op_a_o, accel_op_b_o;
  logic        accel_result_valid_i = 1'b0;
  logic [31:0] accel_result_i = '0;
  logic        irq_o;

  tbd_accel_ctrl #(.IdWidth(1), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_aid_i(obi_aid_i), .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o),
    .obi_rid_o(obi_rid_o), .obi_err_o(obi_err_o),
    .accel_valid_o(accel_valid_o), .accel_ready_i(accel_ready_i),
    .accel_op_a_o(accel_op_a_o), .accel_op_b_o(accel_op_b_o),
    .accel_result_valid_i(accel_result_valid_i), .accel_result_i(accel_result_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: software-visible registers plus a job record
  // (in flight? accepted by the datapath? elapsed cycles).
  bit          live = 0;
  logic [31:0] m_opa, m_opb, m_result, m_cyc;
  bit          m_irqen, m_done, m_err, m_tout;
  bit          m_job, m_taken;
  bit          e_rvalid, e_err, e_irq;
  logic [31:0] e_rdata;
  logic [0:0]  e_rid;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_ni) begin
        live = 1;
        m_opa = 0; m_opb = 0; m_result = 0; m_cyc = 0;
        m_irqen = 0; m_done = 0; m_err = 0; m_tout = 0;
        m_job = 0; m_taken = 0;
        e_rvalid = 0; e_err = 0; e_irq = 0; e_rdata = 0; e_rid = 0;
      end else if (live) begin
        int  idx;
        bit  was_busy, start, clr, bad, cap, tmo;
        idx = int'(obi_addr_i[9:2]);
        was_busy = m_job;
        start = 0; clr = 0; bad = 0; cap = 0; tmo = 0;
        e_irq = m_done && m_irqen;
        e_rvalid = obi_req_i;
        e_err = 0;
        e_rdata = 0;
        if (obi_req_i) begin
          e_rid = obi_aid_i;
          if (idx > 5) e_err = 1;
          else if (!obi_we_i) begin
            case (idx)
              0: e_rdata = m_irqen ? 32'h2 : 32'h0;
              1: e_rdata = 32'(m_job) + 2 * 32'(m_done) + 4 * 32'(m_err) + 8 * 32'(m_tout);
              2: e_rdata = m_opa;
              3: e_rdata = m_opb;
              4: e_rdata = m_result;
              default: e_rdata = m_cyc;
            endcase
          end else if (idx == 1 || idx == 4 || idx == 5) e_err = 1;
          else if (idx == 0) begin
            if (obi_be_i[0]) begin
              start = obi_wdata_i[0];
              m_irqen = obi_wdata_i[1];
              clr = obi_wdata_i[2];
            end
          end else if (was_busy) bad = 1;
          else begin
            for (int b = 0; b < 4; b++)
              if (obi_be_i[b]) begin
                if (idx == 2) m_opa[8*b +: 8] = obi_wdata_i[8*b +: 8];
                else          m_opb[8*b +: 8] = obi_wdata_i[8*b +: 8];
              end
          end
        end
        if (m_job) begin
          cap = m_taken && accel_result_valid_i;
`ifdef TBD_ACCEL_CTRL_TIMEOUT_EN
          tmo = (m_cyc >= TO) && !cap;
`endif
          if (!tmo) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (!m_taken && accel_ready_i) m_taken = 1;
          end
          if (cap) m_result = accel_result_i;
          if (cap || tmo) m_job = 0;
        end
        if (clr) begin m_done = 0; m_err = 0; m_tout = 0; end
        if (cap || tmo) m_done = 1;
        if (tmo) m_tout = 1;
        if (bad || (start && was_busy)) m_err = 1;
        if (start && !was_busy) begin m_job = 1; m_taken = 0; m_cyc = 0; end
      end
    end
  end

  // Compare process: outputs checked every cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        chk("gnt", obi_gnt_o, obi_req_i);
        chk("rvalid", obi_rvalid_o, e_rvalid);
        chk("rsp_err", obi_err_o, e_err);
        chk("rdata", obi_rdata_o, e_rdata);
        if (e_rvalid) chk("rid", obi_rid_o, e_rid);
        chk("accel_valid", accel_valid_o, m_job && !m_taken);
        if (m_job && !m_taken) begin
          chk("op_a", accel_op_a_o, m_opa);
          chk("op_b", accel_op_b_o, m_opb);
        end
        chk("irq", irq_o, e_irq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obi_wr(input logic [7:0] idx, input logic [31:0] d, input logic [3:0] be,
                        output logic err);
    obi_req_i = 1; obi_we_i = 1; obi_addr_i = {22'd0, idx, 2'b00};
    obi_be_i = be; obi_wdata_i = d; obi_aid_i = 1'b1;
    tick();
    obi_req_i = 0; obi_we_i = 0;
    err = obi_err_o;
  endtask

  task automatic obi_rd(input logic [7:0] idx, output logic [31:0] d, output logic err);
    obi_req_i = 1; obi_we_i = 0; obi_addr_i = {22'd0, idx, 2'b00};
    obi_be_i = 4'hF; obi_aid_i = 1'b0;
    tick();
    obi_req_i = 0;
    d = obi_rdata_o;
    err = obi_err_o;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    repeat (2) tick();
    chk("reset_irq", irq_o, 0);
    chk("reset_valid", accel_valid_o, 0);
    rst_ni = 1;
    obi_rd(8'd1, rd, er);
    chk("reset_status", rd, 32'h0);

    // Basic job: 5 + 7, ready immediately, result three cycles after acceptance.
    obi_wr(8'd2, 32'd5, 4'hF, er);
    obi_wr(8'd3, 32'd7, 4'hF, er);
    accel_ready_i = 1;
    obi_wr(8'd0, 32'h3, 4'h1, er);
    chk("t1_valid", accel_valid_o, 1);
    chk("t1_opa", accel_op_a_o, 5);
    chk("t1_opb", accel_op_b_o, 7);
    repeat (3) tick();
    accel_result_valid_i = 1; accel_result_i = 32'd12;
    tick();
    accel_result_valid_i = 0; accel_ready_i = 0;
    chk("t1_irq_lag", irq_o, 0);
    tick();
    chk("t1_irq", irq_o, 1);
    obi_rd(8'd4, rd, er); chk("t1_result", rd, 12);
    obi_rd(8'd5, rd, er); chk("t1_cycles", rd, 4);
    obi_rd(8'd1, rd, er); chk("t1_status", rd, 32'h2);

    // Backpressure: ten cycles without ready, then result later.
    obi_wr(8'd0, 32'h7, 4'h1, er);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_valid", accel_valid_o, 1);
      chk("t2_opa", accel_op_a_o, 5);
    end
    accel_ready_i = 1; tick(); accel_ready_i = 0;
    obi_rd(8'd1, rd, er); chk("t2_busy", rd, 32'h1);
    accel_result_valid_i = 1; accel_result_i = 32'd99; tick(); accel_result_valid_i = 0;
    obi_rd(8'd1, rd, er); chk("t2_status", rd, 32'h2);

    // Illegal accesses.
    obi_rd(8'h06, rd, er); chk("t3_bad_err", er, 1); chk("t3_bad_rdata", rd, 0);
    obi_wr(8'd4, 32'h1234, 4'hF, er); chk("t3_ro_err", er, 1);
    obi_rd(8'd4, rd, er); chk("t3_result_kept", rd, 99);
    obi_wr(8'd0, 32'h3, 4'h1, er);
    obi_wr(8'd0, 32'h3, 4'h1, er); chk("t3_start_busy_rsp", er, 0);
    obi_wr(8'd2, 32'hDEAD_BEEF, 4'hF, er);
    obi_rd(8'd1, rd, er); chk("t3_status", rd, 32'h7);
    obi_rd(8'd2, rd, er); chk("t3_opa_kept", rd, 5);
    accel_ready_i = 1; tick(); accel_ready_i = 0;
    accel_result_valid_i = 1; accel_result_i = 32'h55; tick(); accel_result_valid_i = 0;
    accel_ready_i = 1;
    repeat (3) begin tick(); chk("t3_no_reissue", accel_valid_o, 0); end
    obi_rd(8'd1, rd, er); chk("t3_status_end", rd, 32'h6);

    // CLR racing the result strobe: DONE set wins, irq stays up.
    obi_wr(8'd0, 32'h3, 4'h1, er);
    tick();
    accel_result_valid_i = 1; accel_result_i = 32'h44;
    obi_wr(8'd0, 32'h6, 4'h1, er);
    accel_result_valid_i = 0;
    chk("t4_irq0", irq_o, 1);
    tick(); chk("t4_irq1", irq_o, 1);
    obi_rd(8'd1, rd, er); chk("t4_status", rd, 32'h2);
    obi_wr(8'd0, 32'h6, 4'h1, er);
    chk("t4_irq_hold", irq_o, 1);
    tick(); chk("t4_irq_fall", irq_o, 0);

    // Reset in WAIT.
    obi_wr(8'd0, 32'h3, 4'h1, er);
    tick();
    rst_ni = 0; tick();
    chk("t5_valid", accel_valid_o, 0);
    rst_ni = 1; accel_result_valid_i = 1; accel_result_i = 32'hBAD; tick();
    accel_result_valid_i = 0; accel_ready_i = 0;
    obi_rd(8'd1, rd, er); chk("t5_status", rd, 0);
    obi_rd(8'd4, rd, er); chk("t5_result", rd, 0);

    // Randomized traffic, checked only by the model.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[9:2] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      obi_addr_i  = a;
      obi_req_i   = ($urandom_range(0, 9) < 6);
      obi_we_i    = 1'($urandom);
      obi_be_i    = 4'($urandom);
      obi_wdata_i = $urandom;
      obi_aid_i   = 1'($urandom);
      accel_ready_i        = 1'($urandom);
      accel_result_valid_i = ($urandom_range(0, 4) == 0);
      accel_result_i       = $urandom;
      rst_ni = ($urandom_range(0, 299) != 0);
      tick();
    end
    obi_req_i = 0; accel_result_valid_i = 0; rst_ni = 0; tick(); rst_ni = 1;

    // Datapath accepts but never answers.
    accel_ready_i = 1;
    obi_wr(8'd0, 32'h7, 4'h1, er);
    accel_ready_i = 0;
`ifdef TBD_ACCEL_CTRL_TIMEOUT_EN
    repeat (20) tick();
    obi_rd(8'd1, rd, er); chk("t6_status", rd, 32'hA);
    obi_rd(8'd4, rd, er); chk("t6_result", rd, 0);
    chk("t6_irq", irq_o, 1);
`else
    repeat (10000) tick();
    obi_rd(8'd1, rd, er); chk("t6_busy", rd, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
